branch_gshare_pipelined_predictor: RTL and testbench

- Parametrised gshare direction predictor: PHT of saturating counters indexed by PC XOR speculative global history register (GHR).
- Generalises the fixed 2-bit global predictor with:
  - configurable table depth, counter width and history length
  - post-reset PHT initialisation sweep
  - speculative GHR with mispredict restore
  - two-stage pipelined PHT update with bypass
- Sits beside the fetch stage: prediction is looked up at fetch, and resolution arrives from execute via a val/rdy update port.

---
 rtl/branch_gshare_pipelined_predictor.sv | 147 ++++++++++++++
 tb/tb_branch_gshare_pipelined_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_gshare_pipelined_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_gshare_pipelined_predictor
// Purpose  : Gshare direction predictor. The PHT of saturating counters is
//            indexed by PC XOR a speculative global history register. The
//            table is swept to weakly-not-taken after reset, and resolved
//            updates pass through a two-stage read/modify/write pipe with
//            forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module branch_gshare_pipelined_predictor #(
  parameter int PHT_SIZE  = 2048,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pred_en,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_ghr,
  output logic                 ready,
  input  logic                 update_val,
  output logic                 update_rdy,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_ghr,
  input  logic                 update_taken,
  input  logic                 update_mispred
);

  localparam int                 L      = $clog2(PHT_SIZE);
  localparam logic [L-1:0]        C_LAST = L'(PHT_SIZE - 1);
  localparam logic [CTR_BITS-1:0] C_MAX  = '1;
  localparam logic [CTR_BITS-1:0] C_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                r_state;
  logic [L-1:0]          r_sweep;
  logic [HIST_BITS-1:0]  r_ghr;
  logic                  r_s2_valid;
  logic [L-1:0]          r_s2_idx;
  logic [CTR_BITS-1:0]   r_s2_ctr;
  logic [CTR_BITS-1:0]   r_pht [PHT_SIZE];

  logic [L-1:0]          w_pred_hz;
  logic [L-1:0]          w_upd_hz;
  logic [L-1:0]          w_pred_idx;
  logic [L-1:0]          w_upd_idx;
  logic [HIST_BITS-1:0]  w_spec_ghr;
  logic [HIST_BITS-1:0]  w_rest_ghr;
  logic [CTR_BITS-1:0]   w_pred_ctr;
  logic [CTR_BITS-1:0]   w_upd_ctr;
  logic [CTR_BITS-1:0]   w_upd_next;
  logic                  w_xfer;
  logic                  w_unused;

  // History folded into the index: truncated when long, zero-extended when short
  if (HIST_BITS >= L) begin : g_hist_trunc
    assign w_pred_hz = r_ghr[L-1:0];
    assign w_upd_hz  = update_ghr[L-1:0];
  end else begin : g_hist_zext
    assign w_pred_hz = {{(L - HIST_BITS){1'b0}}, r_ghr};
    assign w_upd_hz  = {{(L - HIST_BITS){1'b0}}, update_ghr};
  end

  // Next-history values for speculative shift and mispredict restore
  if (HIST_BITS == 1) begin : g_shift_one
    assign w_spec_ghr = pred_taken;
    assign w_rest_ghr = update_taken;
  end else begin : g_shift_many
    assign w_spec_ghr = {r_ghr[HIST_BITS-2:0], pred_taken};
    assign w_rest_ghr = {update_ghr[HIST_BITS-2:0], update_taken};
  end

  assign w_pred_idx = pred_pc[L+1:2] ^ w_pred_hz;
  assign w_upd_idx  = update_pc[L+1:2] ^ w_upd_hz;

  assign ready      = (r_state == RUN);
  assign update_rdy = ready;
  assign w_xfer     = update_val & ready;
  assign pred_ghr   = r_ghr;
  assign pred_taken = ready & w_pred_ctr[CTR_BITS-1];

  // Upper PC bits, byte offset and excess history bits do not reach the index
  assign w_unused = ^{pred_pc, update_pc, update_ghr};

  // Effective counters (stage-2 forwarding) and saturating next value
  always_comb begin
    w_pred_ctr = r_pht[w_pred_idx];
    if (r_s2_valid && (r_s2_idx == w_pred_idx)) w_pred_ctr = r_s2_ctr;
    w_upd_ctr = r_pht[w_upd_idx];
    if (r_s2_valid && (r_s2_idx == w_upd_idx)) w_upd_ctr = r_s2_ctr;
    w_upd_next = w_upd_ctr;
    if (update_taken) begin
      if (w_upd_ctr != C_MAX) w_upd_next = w_upd_ctr + CTR_BITS'(1);
    end else begin
      if (w_upd_ctr != '0) w_upd_next = w_upd_ctr - CTR_BITS'(1);
    end
  end

  // INIT sweeps the table once, then RUN until the next reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else if (r_state == INIT) begin
      r_sweep <= r_sweep + L'(1);
      if (r_sweep == C_LAST) r_state <= RUN;
    end
  end

  // Table write port: sweep fill during INIT, stage-2 commit during RUN
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == INIT) r_pht[r_sweep] <= C_INIT;
      else if (r_s2_valid) r_pht[r_s2_idx] <= r_s2_ctr;
    end
  end

  // Stage 2 register: holds the pending write for one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_ctr   <= '0;
    end else begin
      r_s2_valid <= w_xfer;
      if (w_xfer) begin
        r_s2_idx <= w_upd_idx;
        r_s2_ctr <= w_upd_next;
      end
    end
  end

  // Global history: restore on mispredict takes priority over speculation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ghr <= '0;
    end else if (ready) begin
      if (w_xfer && update_mispred) r_ghr <= w_rest_ghr;
      else if (pred_en)             r_ghr <= w_spec_ghr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_gshare_pipelined_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_gshare_pipelined_predictor
// Purpose  : Directed self-checking bench for the gshare predictor
//            (16-entry table, 2-bit counters, 4-bit history).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_gshare_pipelined_predictor;

  localparam int PHT = 16;
  localparam int CB  = 2;
  localparam int HB  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pred_en;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic [HB-1:0] pred_ghr;
  logic          ready;
  logic          update_val;
  logic          update_rdy;
  logic [31:0]   update_pc;
  logic [HB-1:0] update_ghr;
  logic          update_taken;
  logic          update_mispred;

  int n_assert = 0;
  int n_fail   = 0;

  branch_gshare_pipelined_predictor #(
    .PHT_SIZE (PHT),
    .CTR_BITS (CB),
    .HIST_BITS(HB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pred_en       (pred_en),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_ghr      (pred_ghr),
    .ready         (ready),
    .update_val    (update_val),
    .update_rdy    (update_rdy),
    .update_pc     (update_pc),
    .update_ghr    (update_ghr),
    .update_taken  (update_taken),
    .update_mispred(update_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the last reset edge; counts not-ready cycles
  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 64) begin
      cnt++;
      tick();
    end
    check(tag, cnt, PHT);
  endtask

  // One-cycle update transfer; returns in the cycle stage 2 holds it
  task automatic send(input logic [31:0] pc, input logic [HB-1:0] g,
                      input logic tk, input logic mp);
    update_pc      = pc;
    update_ghr     = g;
    update_taken   = tk;
    update_mispred = mp;
    update_val     = 1'b1;
    tick();
    update_val     = 1'b0;
    update_mispred = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic exp);
    pred_pc = pc;
    #1;
    check(tag, pred_taken, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_up [5];
    logic exp_dn [4];
    exp_up = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_dn = '{1'b1, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; pred_en = 1'b0; pred_pc = '0;
    update_val = 1'b0; update_pc = '0; update_ghr = '0;
    update_taken = 1'b0; update_mispred = 1'b0;

    // Reset state and sweep timing
    tick();
    tick();
    check("rst_ready", ready, 0);
    check("rst_update_rdy", update_rdy, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_ghr", pred_ghr, 0);
    reset_n = 1'b1;
    wait_ready("sweep_cycles");
    check("run_ready", ready, 1);
    check("run_update_rdy", update_rdy, 1);
    for (int i = 0; i < PHT; i++) probe("init_entry", i << 2, 1'b0);

    // Saturation at both ends (index 0)
    for (int i = 0; i < 5; i++) begin
      send(32'h100, '0, 1'b1, 1'b0);
      probe("sat_up_bypass", 32'h100, exp_up[i]);
      tick();
      probe("sat_up_array", 32'h100, exp_up[i]);
    end
    for (int i = 0; i < 4; i++) begin
      send(32'h100, '0, 1'b0, 1'b0);
      probe("sat_dn_bypass", 32'h100, exp_dn[i]);
      tick();
      probe("sat_dn_array", 32'h100, exp_dn[i]);
    end

    // Back-to-back taken updates to index 1: 1 -> 2 -> 3
    send(32'h104, '0, 1'b1, 1'b0);
    update_val = 1'b1;
    probe("b2b_lookup", 32'h104, 1'b1);
    tick();
    update_val = 1'b0;
    tick();
    send(32'h104, '0, 1'b0, 1'b0);
    tick();
    probe("b2b_chain_3to2", 32'h104, 1'b1);
    send(32'h104, '0, 1'b0, 1'b0);
    tick();
    probe("b2b_chain_2to1", 32'h104, 1'b0);

    // Make index 5 strongly taken for the history sequence
    send(32'h14, '0, 1'b1, 1'b0);
    tick();
    send(32'h14, '0, 1'b1, 1'b0);
    tick();
    check("ghr_before_spec", pred_ghr, 0);

    // Speculative history: predictions 1,0,1 -> 0101
    pred_en = 1'b1;
    probe("spec_pred0", 32'h14, 1'b1);
    tick();
    check("spec_ghr0", pred_ghr, 4'b0001);
    probe("spec_pred1", 32'h00, 1'b0);
    tick();
    check("spec_ghr1", pred_ghr, 4'b0010);
    probe("spec_pred2", 32'h1C, 1'b1);
    tick();
    pred_en = 1'b0;
    check("spec_ghr2", pred_ghr, 4'b0101);

    // Mispredict restore: {001, 0}
    send(32'h200, 4'b0001, 1'b0, 1'b1);
    check("restore_ghr", pred_ghr, 4'b0010);
    tick();

    // Restore wins over a same-cycle speculative shift: {110, 1}
    pred_en = 1'b1;
    pred_pc = 32'h0;
    send(32'h300, 4'b0110, 1'b1, 1'b1);
    pred_en = 1'b0;
    check("restore_over_spec", pred_ghr, 4'b1101);

    // Correctly predicted update leaves history alone
    send(32'h14, '0, 1'b1, 1'b0);
    check("no_mispred_ghr", pred_ghr, 4'b1101);
    tick();

    // Reset while index 2 update sits in stage 2
    send(32'h8, '0, 1'b1, 1'b0);
    reset_n = 1'b0;
    pred_en = 1'b1;
    tick();
    check("midrst_ready", ready, 0);
    check("midrst_ghr", pred_ghr, 0);
    probe("midrst_pred_gated", 32'h14, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("init_pred_en_ignored", pred_ghr, 0);
    check("init_ready_low", ready, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_ready("sweep_restart_cycles");
    pred_en = 1'b0;
    check("post_rst_ghr", pred_ghr, 0);
    probe("post_rst_idx5", 32'h14, 1'b0);
    probe("post_rst_idx2", 32'h8, 1'b0);
    send(32'h8, '0, 1'b1, 1'b0);
    probe("post_rst_idx2_up", 32'h8, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
